// File: rtl/imem_fetch.sv
// imem_fetch: loadable DEPTH_WORDS x 32-bit instruction memory with a
// valid/ready fetch port returning {pc, instr, is_c, err}.
// Build option: define IMEM_RVC_EN to accept halfword PCs (RV32C), including
// 32-bit instructions that straddle a word boundary (extra SPLIT cycle).
// With IMEM_RVC_EN undefined every fetch completes in one cycle, words are
// returned whole and any pc[1:0] != 0 is reported as an error.
module imem_fetch #(
  parameter int DEPTH_WORDS = 64,
  parameter int PC_W        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_en,
  input  logic [PC_W-1:0] ld_addr,
  input  logic [31:0]     ld_data,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [PC_W-1:0] req_pc,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [PC_W-1:0] rsp_pc,
  output logic [31:0]     rsp_instr,
  output logic            rsp_is_c,
  output logic            rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. The request side is ready when no response is held or the held
  // response leaves on the same edge; a held response (rsp_valid=1) keeps all
  // rsp_* stable until rsp_ready is seen high.

`ifdef IMEM_RVC_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    SPLIT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1
  } state_t;
`endif

  state_t state, state_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic [PC_W-1:0] pc_d;
  logic [31:0]     instr_d;
  logic            is_c_d;
  logic            err_d;

  logic            accept;
  logic            req_bad;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] ld_idx;
  logic [31:0]     req_word;
  logic            unused_ld_low;

`ifdef IMEM_RVC_EN
  // Low half of a straddling instruction and the index of the word that
  // carries its high half; the extra index bit flags running off the end.
  logic [15:0]     split_half, half_d;
  logic [IDX_W:0]  split_idx, sidx_d;
  logic [31:0]     split_word;
`endif

  // An address is in range when nothing is set above the word-index field.
  function automatic logic in_range(input logic [PC_W-1:0] a);
    return (a >> (IDX_W + 2)) == '0;
  endfunction

  assign req_idx       = req_pc[IDX_W+1:2];
  assign ld_idx        = ld_addr[IDX_W+1:2];
  assign req_word      = mem[req_idx];
  assign unused_ld_low = ^ld_addr[1:0];

`ifdef IMEM_RVC_EN
  assign req_bad    = req_pc[0] || !in_range(req_pc);
  assign split_word = mem[split_idx[IDX_W-1:0]];
`else
  assign req_bad    = (req_pc[1:0] != 2'b00) || !in_range(req_pc);
`endif

  assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  // Program-load port; reset clears the whole array, out-of-range loads drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (ld_en && in_range(ld_addr)) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rsp_pc     <= '0;
      rsp_instr  <= '0;
      rsp_is_c   <= 1'b0;
      rsp_err    <= 1'b0;
`ifdef IMEM_RVC_EN
      split_half <= '0;
      split_idx  <= '0;
`endif
    end else begin
      state      <= state_d;
      rsp_pc     <= pc_d;
      rsp_instr  <= instr_d;
      rsp_is_c   <= is_c_d;
      rsp_err    <= err_d;
`ifdef IMEM_RVC_EN
      split_half <= half_d;
      split_idx  <= sidx_d;
`endif
    end
  end

  // Next-state and next-response decode.
  always_comb begin
    state_d = state;
    pc_d    = rsp_pc;
    instr_d = rsp_instr;
    is_c_d  = rsp_is_c;
    err_d   = rsp_err;
`ifdef IMEM_RVC_EN
    half_d  = split_half;
    sidx_d  = split_idx;
`endif
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_d = RESP;
          pc_d    = req_pc;
          instr_d = '0;
          is_c_d  = 1'b0;
          err_d   = 1'b0;
          if (req_bad) begin
            err_d = 1'b1;
`ifdef IMEM_RVC_EN
          end else if (req_pc[1]) begin
            // Upper half of the word starts the instruction.
            if (req_word[17:16] != 2'b11) begin
              is_c_d  = 1'b1;
              instr_d = {16'h0, req_word[31:16]};
            end else begin
              half_d  = req_word[31:16];
              sidx_d  = {1'b0, req_idx} + {{IDX_W{1'b0}}, 1'b1};
              state_d = SPLIT;
            end
          end else if (req_word[1:0] != 2'b11) begin
            is_c_d  = 1'b1;
            instr_d = {16'h0, req_word[15:0]};
          end else begin
            instr_d = req_word;
`else
          end else begin
            instr_d = req_word;
`endif
          end
        end else if ((state == RESP) && rsp_ready) begin
          state_d = IDLE;
        end
      end
`ifdef IMEM_RVC_EN
      SPLIT: begin
        // Second half comes from the next word, read one cycle after accept.
        state_d = RESP;
        is_c_d  = 1'b0;
        if (split_idx[IDX_W]) begin
          err_d   = 1'b1;
          instr_d = '0;
        end else begin
          err_d   = 1'b0;
          instr_d = {split_word[15:0], split_half};
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: directed scenarios plus a randomized
// sweep, all checked against a byte-address/halfword reference model.
module tb_imem_fetch;

  localparam int DEPTH = 64;
  localparam int PC_W  = 32;
  localparam int BYTES = 4 * DEPTH;

  logic            clk;
  logic            reset;
  logic            ld_en;
  logic [PC_W-1:0] ld_addr;
  logic [31:0]     ld_data;
  logic            req_valid;
  logic            req_ready;
  logic [PC_W-1:0] req_pc;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [PC_W-1:0] rsp_pc;
  logic [31:0]     rsp_instr;
  logic            rsp_is_c;
  logic            rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [33:0] exp_q [$];

  imem_fetch #(.DEPTH_WORDS(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pc(rsp_pc),
    .rsp_instr(rsp_instr), .rsp_is_c(rsp_is_c), .rsp_err(rsp_err)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[int'(a >> 2)];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic model_load(input logic [31:0] a, input logic [31:0] d);
    if (a < 32'(BYTES)) ref_mem[int'(a >> 2)] = d;
  endtask

  // Instruction at byte address pc: a halfword whose low bits are 11 starts
  // a 32-bit instruction that takes the following halfword as its top half.
  task automatic model_fetch(input logic [31:0] pc, output logic [31:0] instr,
                             output logic c, output logic err, output int lat);
    logic [15:0] lo;
    instr = '0; c = 1'b0; err = 1'b0; lat = 1;
`ifdef IMEM_RVC_EN
    if (pc[0] || pc >= 32'(BYTES)) begin
      err = 1'b1;
    end else begin
      lo = half_at(pc);
      if (lo[1:0] != 2'b11) begin
        c = 1'b1;
        instr = {16'h0, lo};
      end else begin
        if (pc[1]) lat = 2;
        if (pc + 32'd2 >= 32'(BYTES)) err = 1'b1;
        else instr = {half_at(pc + 32'd2), lo};
      end
    end
`else
    lo = '0;
    if (pc[1:0] != 2'b00 || pc >= 32'(BYTES)) err = 1'b1;
    else instr = ref_mem[int'(pc >> 2)];
    if (lo != 16'h0) err = 1'b1;
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    model_load(a, d);
  endtask

  // One fetch from IDLE, optional same-cycle load, optional response stall.
  task automatic fetch_one(input string name, input logic [31:0] pc,
                           input bit do_ld, input logic [31:0] la,
                           input logic [31:0] ld_d, input int stall);
    logic [31:0] e_instr;
    logic        e_c, e_err;
    int          e_lat;
    logic [66:0] exp_v, got_v;
    model_fetch(pc, e_instr, e_c, e_err, e_lat);
    if (do_ld) begin
      model_load(la, ld_d);
      // The straddle's second half is read after the load has landed.
      if (e_lat == 2 && !e_err) e_instr[31:16] = half_at(pc + 32'd2);
    end
    rsp_ready = (stall == 0);
    req_valid = 1'b1; req_pc = pc;
    ld_en = do_ld; ld_addr = la; ld_data = ld_d;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready_idle got %b exp 1", name, req_ready);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = 1'b0; ld_en = 1'b0;
    if (e_lat == 2) begin
      n_checks++;
      if ({rsp_valid, req_ready} !== 2'b00)
        $display("FAIL %s split_cycle valid/ready got %b%b exp 00", name, rsp_valid, req_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    exp_v = {1'b1, pc, e_instr, e_c, e_err};
    for (int k = 0; k <= stall; k++) begin
      got_v = {rsp_valid, rsp_pc, rsp_instr, rsp_is_c, rsp_err};
      n_checks++;
      if (got_v !== exp_v)
        $display("FAIL %s rsp[%0d] got v=%b pc=%h instr=%h c=%b err=%b exp v=1 pc=%h instr=%h c=%b err=%b",
                 name, k, rsp_valid, rsp_pc, rsp_instr, rsp_is_c, rsp_err, pc, e_instr, e_c, e_err);
      else n_pass++;
      if (k < stall) begin
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL %s req_ready_stall got %b exp 0", name, req_ready);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL %s drain rsp_valid got %b exp 0", name, rsp_valid);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    n_checks++;
    if ({rsp_valid, rsp_pc, rsp_instr, rsp_is_c, rsp_err} !== 67'h0)
      $display("FAIL reset_outputs got v=%b pc=%h instr=%h c=%b err=%b exp all 0",
               rsp_valid, rsp_pc, rsp_instr, rsp_is_c, rsp_err);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready);
    else n_pass++;
    fetch_one("reset_mem0", 32'd0, 1'b0, '0, '0, 0);
  endtask

  task automatic test_aligned();
    do_load(32'd0, 32'h0000_40F9);
    fetch_one("compressed_pc0", 32'd0, 1'b0, '0, '0, 0);
    do_load(32'd12, 32'h0031_0133);
    fetch_one("word_pc12_stall", 32'd12, 1'b0, '0, '0, 3);
  endtask

  task automatic test_straddle();
    do_load(32'd16, 32'hA013_0000);
    do_load(32'd20, 32'h0000_4123);
    fetch_one("straddle_pc18", 32'd18, 1'b0, '0, '0, 0);
    fetch_one("upper_c_pc22", 32'd22, 1'b0, '0, '0, 1);
  endtask

  task automatic test_errors();
    fetch_one("oor_pc256", 32'd256, 1'b0, '0, '0, 0);
    fetch_one("odd_pc255", 32'd255, 1'b0, '0, '0, 0);
    do_load(32'd252, 32'h0003_0000);
    fetch_one("straddle_end_pc254", 32'd254, 1'b0, '0, '0, 0);
    fetch_one("oor_high_bit", 32'h8000_0000, 1'b0, '0, '0, 0);
    do_load(32'd256, 32'hFFFF_FFFF);
    fetch_one("oor_load_dropped", 32'd0, 1'b0, '0, '0, 0);
  endtask

  task automatic test_load_same_cycle();
    do_load(32'd8, 32'h1234_5673);
    fetch_one("same_cycle_old", 32'd8, 1'b1, 32'd8, 32'hDEAD_BEEF, 0);
    fetch_one("next_fetch_new", 32'd8, 1'b0, '0, '0, 0);
  endtask

  task automatic test_back_to_back(input bit with_reset);
    logic [31:0] e_instr;
    logic        e_c, e_err;
    int          e_lat;
    logic [33:0] e;
    for (int i = 0; i < 8; i++) do_load(32'(4 * i), $urandom());
    exp_q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({rsp_valid, rsp_pc, rsp_instr, rsp_is_c, rsp_err} !== {1'b1, 32'(4 * (i - 1)), e})
          $display("FAIL b2b[%0d] got v=%b pc=%h instr=%h c=%b err=%b exp pc=%h instr=%h c=%b err=%b",
                   i - 1, rsp_valid, rsp_pc, rsp_instr, rsp_is_c, rsp_err,
                   32'(4 * (i - 1)), e[33:2], e[1], e[0]);
        else n_pass++;
      end
      if (with_reset && i == 5) break;
      if (i < 8) begin
        model_fetch(32'(4 * i), e_instr, e_c, e_err, e_lat);
        exp_q.push_back({e_instr, e_c, e_err});
        req_valid = 1'b1; req_pc = 32'(4 * i);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b exp 1", i, req_ready);
        else n_pass++;
        if (with_reset && i == 4) reset = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (with_reset && i == 4) begin
        reset = 1'b0; req_valid = 1'b0;
        model_clear();
        exp_q.delete();
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL b2b_tail[%0d] rsp_valid got %b exp 0", k, rsp_valid);
      else n_pass++;
      @(posedge clk); #1;
    end
    if (with_reset) begin
      fetch_one("post_reset_w0", 32'd0, 1'b0, '0, '0, 0);
      fetch_one("post_reset_w7", 32'd28, 1'b0, '0, '0, 0);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, la;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        la = ($urandom_range(0, 7) == 0) ? 32'(BYTES + $urandom_range(0, 255))
                                         : 32'($urandom_range(0, BYTES - 1));
        do_load(la, $urandom());
      end
      case ($urandom_range(0, 9))
        0:       pc = 32'($urandom_range(0, BYTES - 1)) | 32'd1;
        1:       pc = $urandom();
        2:       pc = 32'(BYTES - 2);
        default: pc = 32'($urandom_range(0, BYTES - 1)) & ~32'd1;
      endcase
      la = 32'($urandom_range(0, BYTES - 1));
      fetch_one("random", pc, ($urandom_range(0, 2) == 0), la, $urandom(),
                int'($urandom_range(0, 2)));
    end
  endtask

  // Main sequence.
  initial begin
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
    model_clear();
    @(posedge clk); #1;
    test_reset();
    test_aligned();
    test_straddle();
    test_errors();
    test_load_same_cycle();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised, loadable instruction memory with a valid/ready fetch port. It succeeds the fixed 64-entry register-file instruction memory. It holds DEPTH_WORDS 32-bit words, is filled at run time through a load port, and returns one instruction per fetch as a {pc, instr, is_c, err} response. Halfword-aligned RV32C fetch is supported, including 32-bit instructions that straddle a word boundary. It sits between the PC/fetch stage and the decode register.

## Interface
Parameters:
- DEPTH_WORDS, 64, number of 32-bit words; power of two, 4..1024
- PC_W, 32, width of fetch and load byte addresses

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- ld_en  in  1  program-load write strobe
- ld_addr  in  PC_W  byte address of the load word; bits [1:0] ignored
- ld_data  in  32  word to write
- req_valid  in  1  fetch request valid
- req_ready  out  1  fetch request accepted when high together with req_valid
- req_pc  in  PC_W  byte PC to fetch
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts the response
- rsp_pc  out  PC_W  PC of the returned instruction
- rsp_instr  out  32  instruction; compressed ones are zero-extended {16'h0, half}
- rsp_is_c  out  1  instruction is 16-bit (low bits != 2'b11)
- rsp_err  out  1  misaligned or out-of-range fetch; rsp_instr = 0

## Operation
- Storage: DEPTH_WORDS × 32-bit flop array. Word index is addr[log2(DEPTH_WORDS)+1:2]. Any address with a set bit above that field is out of range.
- Load: when ld_en=1 and the address is in range, mem[idx] <= ld_data at the edge. Out-of-range loads are dropped silently.
- Word read: the array read is combinational; read data is captured into the response register.
- FSM states:
  - IDLE: no response held.
  - RESP: response held, rsp_valid=1.
  - SPLIT: low half of a straddling instruction held, fetching the high half.
- req_ready = (state==IDLE) || (state==RESP && rsp_ready).
- Accept in IDLE/RESP (aligned pc, pc[1]=0):
  - Read word w; rsp_instr = w, rsp_is_c=0 if w[1:0]==2'b11.
  - Otherwise rsp_is_c=1 and rsp_instr = {16'h0, w[15:0]}.
  - Next state is RESP.
- Accept with pc[1]=1 (RVC only): let h = word[31:16].
  - If h[1:0]!=2'b11: respond with the compressed {16'h0,h}; next state RESP.
  - Else latch h; next state SPLIT.
- SPLIT:
  - Read word idx+1 and form rsp_instr = {word1[15:0], h}, is_c=0; next state RESP.
  - If idx+1 is out of range: rsp_err=1, rsp_instr=0.
- Errors: an out-of-range index, or pc[0]=1, gives err=1, is_c=0, instr=0. An error response does not stall; it completes like a normal one.
- RESP with rsp_ready=1 and no new request: next state IDLE. RESP with rsp_ready=0 holds all rsp_* stable.
- rsp_pc always equals the accepted req_pc.
- Load/fetch same cycle, same word: the fetch returns the old contents; the new word is visible from the next cycle. In SPLIT, the second-half read sees any load completed in the previous cycle.

## Timing
- Reset (overrides ld_en and req):
  - state = IDLE; all memory words = 32'h0.
  - rsp_valid=0, rsp_pc=0, rsp_instr=0, rsp_is_c=0, rsp_err=0.
  - req_ready=1 from the first cycle after reset.
- Latency, accept edge to rsp_valid: 1 cycle for aligned, compressed, or error fetches; 2 cycles for straddling fetches. req_ready=0 while in SPLIT.
- Throughput: back-to-back one per cycle when rsp_ready is held high and there are no straddles.
- Reset asserted mid-SPLIT or mid-RESP: the pending response is discarded and no rsp_valid is produced.

## Configuration
- IMEM_RVC_EN defined:
  - Halfword PCs are accepted, the SPLIT state exists, and rsp_is_c is computed as above.
- IMEM_RVC_EN undefined:
  - Any pc[1:0]!=0 gives err=1.
  - rsp_is_c is tied 0 and every word is returned whole.
  - The SPLIT state is not built; latency is always 1.

## Test plan
- Reset, then load word 0 = 32'h0000_40F9 and fetch pc 0 → 1 cycle later: rsp_instr=32'h0000_40F9, is_c=1, err=0, pc=0.
- Load word 3 = 32'h0031_0133 and fetch pc 12 → instr=32'h0031_0133, is_c=0; hold rsp_ready=0 for 3 cycles → outputs stable, req_ready=0.
- RVC straddle: word 4 = 32'hA013_0000, word 5 = 32'h0000_4123; fetch pc 18 → rsp_valid 2 cycles after accept, instr=32'h4123_A013, is_c=0, pc=18.
- Fetch pc 4×DEPTH_WORDS (256) → err=1, instr=0. Fetch pc 255 → err=1. Fetch pc 254 with word 63 high half [1:0]=2'b11 → err=1 after the SPLIT cycle.
- Same-cycle load of word 2 = 32'hDEAD_BEEF with fetch of pc 8 → old value returned; the next fetch of pc 8 → 32'hDEAD_BEEF.
- Stream 8 aligned fetches with rsp_ready=1 → 8 responses on consecutive cycles. Assert reset during the 5th → no further rsp_valid, and memory reads back 0.
